hilo_mdu: RTL and testbench

Owner of the architectural HI/LO registers in the EX stage. It is the write-side partner of the ALU.
- It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EX.
- Multiplies complete over a fixed short latency; divides run as an iterative divider.
- It stalls the pipeline while busy.
- The registered `hi`/`lo` values are presented back to the ALU for MFHI/MFLO.

---
 rtl/hilo_mdu_pkg.sv | 25 ++
 rtl/hilo_mdu_if.sv | 17 +
 rtl/hilo_mdu_div_iter.sv | 54 +++++
 rtl/hilo_mdu.sv | 96 +++++++++
 tb/tb_hilo_mdu.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/hilo_mdu_pkg.sv
// hilo_mdu_pkg: shared EX control codes, HI/LO unit FSM encodings and op decode helpers.
//   MULT/MULTU/MTHI/MTLO codes are the existing shared values; DIV/DIVU take unused 5-bit codes.
package hilo_mdu_pkg;

    localparam logic [4:0] MULT_CONTROL  = 5'b01100;
    localparam logic [4:0] MULTU_CONTROL = 5'b01101;
    localparam logic [4:0] MTHI_CONTROL  = 5'b01110;
    localparam logic [4:0] MTLO_CONTROL  = 5'b01111;
    localparam logic [4:0] DIV_CONTROL   = 5'b11000;
    localparam logic [4:0] DIVU_CONTROL  = 5'b11001;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    function automatic logic is_mul(input logic [4:0] op);
        return op == MULT_CONTROL || op == MULTU_CONTROL;
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return op == DIV_CONTROL || op == DIVU_CONTROL;
    endfunction

endpackage

// File: rtl/hilo_mdu_if.sv
// hilo_mdu_if: EX-stage request/response bundle for the HI/LO unit.
//   master (EX): drives valid, op, a, b, flush; sees stall, hi, lo, done.
//   slave (hilo_mdu): the reverse.
interface hilo_mdu_if;
    logic        valid;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;

    modport master (output valid, op, a, b, flush, input stall, hi, lo, done);
    modport slave  (input valid, op, a, b, flush, output stall, hi, lo, done);
endinterface

// File: rtl/hilo_mdu_div_iter.sv
// div_iter: 32-bit radix-2 restoring divider on unsigned magnitudes, one step per cycle.
//   clk, rst_n   : clock, async active-low reset
//   start        : load dividend/divisor, clear remainder and iteration counter
//   step         : perform one shift/subtract iteration
//   quotient     : quotient after the current step (combinational look-ahead)
//   remainder    : remainder after the current step (combinational look-ahead)
//   last         : the current step is the final one
module div_iter #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        step,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        last
);
    localparam int CW = $clog2(DIV_CYCLES);

    logic [CW-1:0] cnt;
    logic [31:0]   q, r, d;
    logic [32:0]   sh;
    logic [31:0]   diff;
    logic          ge;

    // Remainder stays below the divisor, so the shifted value fits 33 bits and
    // a successful subtraction always fits back into 32.
    assign sh        = {r, q[31]};
    assign ge        = sh >= {1'b0, d};
    assign diff      = sh[31:0] - d;
    assign quotient  = {q[30:0], ge};
    assign remainder = ge ? diff : sh[31:0];
    assign last      = cnt == CW'(DIV_CYCLES - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            q   <= '0;
            r   <= '0;
            d   <= '0;
            cnt <= '0;
        end else if (start) begin
            q   <= dividend;
            r   <= '0;
            d   <= divisor;
            cnt <= '0;
        end else if (step) begin
            q   <= quotient;
            r   <= remainder;
            cnt <= cnt + 1'b1;
        end
endmodule

// File: rtl/hilo_mdu.sv
// hilo_mdu: EX-stage owner of architectural HI/LO; handles MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//   clk, rst_n : clock, async active-low reset
//   bus.valid/op/a/b/flush : EX request; flush kills it and aborts any op in flight
//   bus.stall  : combinational pipeline hold while a multiply/divide is outstanding
//   bus.hi/lo  : registered HI/LO, read back by the ALU for MFHI/MFLO
//   bus.done   : one-cycle pulse in the cycle after a MULT/DIV result is written
module hilo_mdu
    import hilo_mdu_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input logic       clk,
    input logic       rst_n,
    hilo_mdu_if.slave bus
);
    logic [1:0]  state;
    logic [31:0] hi, lo, ma, mb, q, r, dvd, dvs;
    logic [63:0] prod;
    logic        msgn, sa, sb, bz, req, dsgn, last;

    assign req  = state == S_IDLE && bus.valid && !bus.flush;
    assign dsgn = bus.op == DIV_CONTROL;
    assign dvd  = dsgn && bus.a[31] ? -bus.a : bus.a;
    assign dvs  = dsgn && bus.b[31] ? -bus.b : bus.b;
    // Sign-extending both factors to 64 bits makes the low half of one
    // multiplier correct for both signed and unsigned products.
    assign prod = {{32{msgn & ma[31]}}, ma} * {{32{msgn & mb[31]}}, mb};

    assign bus.stall = (req && (is_mul(bus.op) || is_div(bus.op))) || state == S_MUL || state == S_DIV;
    assign bus.hi    = hi;
    assign bus.lo    = lo;

    div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (req && is_div(bus.op)),
        .dividend  (dvd),
        .divisor   (dvs),
        .step      (state == S_DIV),
        .quotient  (q),
        .remainder (r),
        .last      (last)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= S_IDLE;
            hi       <= '0;
            lo       <= '0;
            bus.done <= 1'b0;
            ma       <= '0;
            mb       <= '0;
            msgn     <= 1'b0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            bz       <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (bus.flush)
                state <= S_IDLE;
            else
                case (state)
                    S_IDLE: if (bus.valid) begin
                        if (bus.op == MTHI_CONTROL) hi <= bus.a;
                        if (bus.op == MTLO_CONTROL) lo <= bus.a;
                        if (is_mul(bus.op)) begin
                            ma    <= bus.a;
                            mb    <= bus.b;
                            msgn  <= bus.op == MULT_CONTROL;
                            state <= S_MUL;
                        end
                        if (is_div(bus.op)) begin
                            sa    <= dsgn & bus.a[31];
                            sb    <= dsgn & bus.b[31];
                            bz    <= bus.b == '0;
                            state <= S_DIV;
                        end
                    end
                    S_MUL: begin
                        {hi, lo} <= prod;
                        bus.done <= 1'b1;
                        state    <= S_DONE;
                    end
                    S_DIV: if (last) begin
                        // A zero divisor leaves an all-ones quotient and |a| as remainder;
                        // skipping the quotient negation and restoring the dividend's sign
                        // yields lo=FFFF_FFFF, hi=a for every divide-by-zero.
                        lo       <= (sa ^ sb) && !bz ? -q : q;
                        hi       <= sa ? -r : r;
                        bus.done <= 1'b1;
                        state    <= S_DONE;
                    end
                    default: state <= S_IDLE;
                endcase
        end
endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: directed and randomized checks of hilo_mdu against an arithmetic reference model.
module tb_hilo_mdu;
    import hilo_mdu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hilo_mdu_if bus();
    hilo_mdu dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;
    time last_done = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Result as {hi, lo}, straight from the architectural definition of each op.
    function automatic logic [63:0] ref_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        if (op == MULT_CONTROL)  return 64'(longint'(sa) * longint'(sb));
        if (op == MULTU_CONTROL) return {32'b0, a} * {32'b0, b};
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (op == DIVU_CONTROL) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge with an empty EX slot; returns at a negedge with the slot free again.
    task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit keep);
        int n;
        bit early, md;
        logic [63:0] e;
        md = is_mul(op) || is_div(op);
        bus.valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.flush = 1'b0;
        #1;
        check("stall_issue", 64'(bus.stall), 64'(md));
        if (!md) begin
            if (op == MTHI_CONTROL) mhi = a;
            if (op == MTLO_CONTROL) mlo = a;
            @(negedge clk);
            if (!keep) bus.valid = 1'b0;
            check("mt_hilo", {bus.hi, bus.lo}, {mhi, mlo});
            return;
        end
        n = 0;
        early = 0;
        while (bus.stall && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.stall && bus.done) early = 1;
        end
        check("latency", 64'(n), is_mul(op) ? 64'd2 : 64'd33);
        check("done_early", 64'(early), 64'd0);
        check("done", 64'(bus.done), 64'd1);
        e = ref_md(op, a, b);
        {mhi, mlo} = e;
        check("md_hilo", {bus.hi, bus.lo}, e);
        last_done = $time;
        @(negedge clk);
        if (!keep) bus.valid = 1'b0;
        check("done_clear", 64'(bus.done), 64'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [63:0] pre;
        time t1;
        bit seen;
        logic [4:0] ops [6];
        ops = '{MTHI_CONTROL, MTLO_CONTROL, MULT_CONTROL, MULTU_CONTROL, DIV_CONTROL, DIVU_CONTROL};
        bus.valid = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_hilo", {bus.hi, bus.lo}, 64'h0);
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);

        run(MTHI_CONTROL, 32'h1234_5678, 32'h0, 0);
        check("mthi_val", 64'(bus.hi), 64'h1234_5678);
        run(MTLO_CONTROL, 32'h9ABC_DEF0, 32'h0, 0);
        check("mtlo_val", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);

        run(MULT_CONTROL, 32'hFFFF_FFFE, 32'd3, 0);
        check("mult_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run(MULTU_CONTROL, 32'hFFFF_FFFE, 32'd3, 0);
        check("multu", {bus.hi, bus.lo}, 64'h0000_0002_FFFF_FFFA);
        run(DIV_CONTROL, -32'sd7, 32'd2, 0);
        check("div_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run(DIVU_CONTROL, 32'd7, 32'd2, 0);
        check("divu", {bus.hi, bus.lo}, 64'h0000_0001_0000_0003);
        run(DIV_CONTROL, 32'h55, 32'h0, 0);
        check("div_zero", {bus.hi, bus.lo}, 64'h0000_0055_FFFF_FFFF);
        run(DIV_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_ovf", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        pre = {mhi, mlo};
        bus.valid = 1'b1;
        bus.op = DIVU_CONTROL;
        bus.a = $urandom;
        bus.b = $urandom | 32'h1;
        repeat (11) @(negedge clk);
        check("flush_pre_stall", 64'(bus.stall), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.valid = 1'b0;
        #1;
        check("flush_stall", 64'(bus.stall), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        check("flush_no_done", 64'(seen), 64'd0);
        check("flush_hilo", {bus.hi, bus.lo}, pre);

        bus.valid = 1'b1;
        bus.op = MTHI_CONTROL;
        bus.a = 32'hDEAD_BEEF;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.valid = 1'b0;
        check("flush_mthi", {bus.hi, bus.lo}, pre);

        run(MULT_CONTROL, 32'd5, 32'd7, 1);
        t1 = last_done;
        run(MULT_CONTROL, -32'sd3, 32'd9, 0);
        check("b2b_gap", 64'(last_done - t1), 64'd30);
        check("b2b_second", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFE5);

        repeat (40) run(ops[$urandom_range(0, 5)], rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
        bus.valid = 1'b0;

        @(negedge clk);
        bus.valid = 1'b1;
        bus.op = DIV_CONTROL;
        bus.a = 32'd100;
        bus.b = 32'd7;
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        bus.valid = 1'b0;
        #1;
        check("amid_rst_hilo", {bus.hi, bus.lo}, 64'h0);
        check("amid_rst_stall", 64'(bus.stall), 64'd0);
        check("amid_rst_done", 64'(bus.done), 64'd0);
        mhi = '0;
        mlo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(DIVU_CONTROL, 32'd100, 32'd7, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
